// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, field positions, exception codes.
package cp0_pkg;
  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  localparam int SR_IE       = 0;
  localparam int SR_EXL      = 1;
  localparam int IM_LO       = 10;
  localparam int IM_HI       = 15;
  localparam int CAUSE_BD    = 31;
  localparam int EXC_LO      = 2;
  localparam int EXC_HI      = 6;

  localparam logic [31:0] SR_MASK    = 32'h0000_FC03;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;
endpackage

// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC/PRId, zero-latency exception/interrupt request for the M stage.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h2023_0701,
  parameter logic [31:0] SR_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A_rd,
  input  logic [4:0]  A_wr,
  input  logic [31:0] Din,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] Dout
);
  logic [31:0] sr_q, sr_d;
  logic [31:0] epc_q, epc_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic        int_req, exc_req;
  logic [31:0] vpc_al, din_al, cause;
  logic        epc_wr;

  assign vpc_al = VPC & ALIGN_MASK;
  assign din_al = Din & ALIGN_MASK;
  assign epc_wr = WE && (A_wr == ADDR_EPC);
  assign cause  = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};

  always_comb begin
    int_req = sr_q[SR_IE] & ~sr_q[SR_EXL] & (|(HWInt & sr_q[IM_HI:IM_LO]));
    exc_req = ~sr_q[SR_EXL] & (ExcCodeIn != EXC_INT);
    Req     = int_req | exc_req;
  end

  always_comb begin
    sr_d  = sr_q;
    epc_d = epc_q;
    bd_d  = bd_q;
    exc_d = exc_q;
    ip_d  = HWInt;
    if (Req) begin
      // The victim is cancelled, so any concurrent mtc0 is dropped.
      sr_d[SR_EXL] = 1'b1;
      bd_d         = BDIn;
      exc_d        = int_req ? EXC_INT : ExcCodeIn;
      epc_d        = BDIn ? vpc_al - 32'd4 : vpc_al;
    end else begin
      if (WE && A_wr == ADDR_SR) sr_d = Din & SR_MASK;
      if (epc_wr)                epc_d = din_al;
      if (EXLClr)                sr_d[SR_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q  <= SR_RESET & SR_MASK;
      epc_q <= '0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
    end else begin
      sr_q  <= sr_d;
      epc_q <= epc_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
    end
  end

  always_comb begin
    case (A_rd)
      ADDR_SR:    Dout = sr_q;
      ADDR_CAUSE: Dout = cause;
      ADDR_EPC:   Dout = epc_q;
      ADDR_PRID:  Dout = PRID_VAL;
      default:    Dout = '0;
    endcase
  end

  // Forward an mtc0 EPC in M to an eret sitting in D.
  assign EPCOut = epc_wr ? din_al : epc_q;
endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit.
module tb_cp0_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A_rd, A_wr, ExcCodeIn;
  logic [31:0] Din, VPC;
  logic        WE, BDIn, EXLClr;
  logic [5:0]  HWInt;
  logic        Req;
  logic [31:0] EPCOut, Dout;
  int          n_cmp = 0;
  int          n_bad = 0;

  cp0_unit dut (
    .clk(clk), .reset(reset), .A_rd(A_rd), .A_wr(A_wr), .Din(Din), .WE(WE),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .EXLClr(EXLClr), .HWInt(HWInt),
    .Req(Req), .EPCOut(EPCOut), .Dout(Dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    A_rd = a;
    #1;
    chk(tag, Dout, exp);
  endtask

  // Advance one edge, return at the next falling edge with inputs idle.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    WE = 0; A_wr = 0; Din = 0; ExcCodeIn = 0; BDIn = 0; EXLClr = 0; VPC = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    WE = 1; A_wr = a; Din = d;
    step();
  endtask

  task automatic eret();
    EXLClr = 1;
    step();
  endtask

  initial begin
    reset = 0; A_rd = 0; A_wr = 0; Din = 0; WE = 0; VPC = 0; BDIn = 0;
    ExcCodeIn = 0; EXLClr = 0; HWInt = 0;
    #12;
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("rst_prid", 5'd15, 32'h2023_0701);
    chk("rst_req", {31'd0, Req}, 32'h0);
    @(negedge clk); reset = 1;
    step();
    rd("rel_epc", 5'd14, 32'h0);

    // overflow
    ExcCodeIn = 5'd12; VPC = 32'h3010; #1;
    chk("ov_req", {31'd0, Req}, 32'h1);
    step();
    rd("ov_epc", 5'd14, 32'h3010);
    rd("ov_cause", 5'd13, 32'h0000_0030);
    rd("ov_sr", 5'd12, 32'h0000_0002);
    eret();
    rd("eret1_sr", 5'd12, 32'h0);

    // delay slot
    ExcCodeIn = 5'd10; BDIn = 1; VPC = 32'h3024;
    step();
    rd("bd_epc", 5'd14, 32'h3020);
    rd("bd_cause", 5'd13, 32'h8000_0028);
    eret();

    // interrupt gating
    mtc0(5'd12, 32'h0000_0401);
    rd("sr_wr", 5'd12, 32'h0000_0401);
    HWInt = 6'b000001; VPC = 32'h4000; #1;
    chk("int_req", {31'd0, Req}, 32'h1);
    step();
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_epc", 5'd14, 32'h4000);
    HWInt = 0;
    eret();
    mtc0(5'd12, 32'h0000_0400);
    HWInt = 6'b000001; #1;
    chk("ie0_req", {31'd0, Req}, 32'h0);
    step();
    rd("ie0_ip", 5'd13, 32'h0000_0400);
    mtc0(5'd12, 32'h0000_0001);
    #1;
    chk("im0_req", {31'd0, Req}, 32'h0);
    rd("im0_ip", 5'd13, 32'h0000_0400);
    HWInt = 0;

    // nesting and eret
    ExcCodeIn = 5'd12; VPC = 32'h100;
    step();
    ExcCodeIn = 5'd8; #1;
    chk("nest_req", {31'd0, Req}, 32'h0);
    step();
    eret();
    rd("eret_sr", 5'd12, 32'h0000_0001);
    ExcCodeIn = 5'd8; VPC = 32'h200; #1;
    chk("sys_req", {31'd0, Req}, 32'h1);
    step();
    rd("sys_cause", 5'd13, 32'h0000_0020);
    rd("sys_epc", 5'd14, 32'h200);
    eret();

    // simultaneous events
    WE = 1; A_wr = 5'd14; Din = 32'h5000; ExcCodeIn = 5'd4; VPC = 32'h600; #1;
    chk("sim_req", {31'd0, Req}, 32'h1);
    step();
    rd("sim_epc", 5'd14, 32'h600);
    WE = 1; A_wr = 5'd14; Din = 32'h5004; EXLClr = 1; #1;
    chk("fwd_req", {31'd0, Req}, 32'h0);
    chk("fwd_epcout", EPCOut, 32'h5004);
    step();
    rd("fwd_epc", 5'd14, 32'h5004);
    rd("fwd_sr", 5'd12, 32'h0000_0001);
    chk("idle_epcout", EPCOut, 32'h5004);

    // boundaries: wrap, unaligned write, unmapped reads/writes
    ExcCodeIn = 5'd5; BDIn = 1; VPC = 32'h0;
    step();
    rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    rd("wrap_cause", 5'd13, 32'h8000_0014);
    eret();
    mtc0(5'd14, 32'h1237);
    rd("align_epc", 5'd14, 32'h1234);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("cause_ro", 5'd13, 32'h8000_0014);
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd("sr_mask", 5'd12, 32'h0000_FC03);
    rd("unmapped", 5'd3, 32'h0);

    // async reset while a request is pending
    mtc0(5'd12, 32'h0);
    ExcCodeIn = 5'd12; VPC = 32'h7000; #1;
    reset = 0; #1;
    rd("arst_epc", 5'd14, 32'h0);
    rd("arst_sr", 5'd12, 32'h0);
    @(posedge clk); #1;
    rd("arst_hold", 5'd14, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
